// File: rtl/comparator_scan_seg.sv
// Registered magnitude comparator (unsigned or two's-complement) with an 8-digit multiplexed hex display.
// Optional macro LEADING_ZERO_BLANK_EN blanks nibbles above each operand's most significant nonzero nibble.
module comparator_scan_seg #(
   parameter int WIDTH    = 8,
   parameter int SIGNED   = 0,
   parameter int SCAN_DIV = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             load,
   output logic [2:0]       O,
   output logic             valid,
   output logic [7:0]       seg_data,
   output logic [7:0]       seg_com
);
   localparam int ND = (WIDTH + 3) / 4;
   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

   logic [WIDTH-1:0] a_r, b_r;
   logic [CW-1:0]    cnt;
   logic [2:0]       idx;
   logic             gt, eq;
   logic [15:0]      a_ext, b_ext, opnd;
   logic [1:0]       pos;
   logic [3:0]       nib;
   logic             blank;
`ifdef LEADING_ZERO_BLANK_EN
   logic [1:0]       top;
`endif

   function automatic logic [7:0] decode(input logic [3:0] n);
      case (n)
         4'h0: decode = 8'h3F;  4'h1: decode = 8'h06;
         4'h2: decode = 8'h5B;  4'h3: decode = 8'h4F;
         4'h4: decode = 8'h66;  4'h5: decode = 8'h6D;
         4'h6: decode = 8'h7D;  4'h7: decode = 8'h07;
         4'h8: decode = 8'h7F;  4'h9: decode = 8'h6F;
         4'hA: decode = 8'h77;  4'hB: decode = 8'h7C;
         4'hC: decode = 8'h39;  4'hD: decode = 8'h5E;
         4'hE: decode = 8'h79;  default: decode = 8'h71;
      endcase
   endfunction

   // Compare the live inputs so O always agrees with the operands captured on the same edge.
   always_comb begin
      eq = (A == B);
      if (SIGNED != 0) gt = $signed(A) > $signed(B);
      else             gt = A > B;
   end

   always_comb begin
      a_ext = '0;
      a_ext[WIDTH-1:0] = a_r;
      b_ext = '0;
      b_ext[WIDTH-1:0] = b_r;
      opnd  = idx[2] ? a_ext : b_ext;
      pos   = idx[1:0];
      nib   = opnd[4*pos +: 4];
      blank = (int'(pos) >= ND);
`ifdef LEADING_ZERO_BLANK_EN
      top = 2'd0;
      for (int p = 1; p < 4; p++)
         if (opnd[4*p +: 4] != 4'h0) top = 2'(p);
      if (pos > top) blank = 1'b1;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= '0;
         b_r   <= '0;
         O     <= 3'b000;
         valid <= 1'b0;
      end else if (load) begin
         a_r   <= A;
         b_r   <= B;
         O     <= gt ? 3'b100 : (eq ? 3'b010 : 3'b001);
         valid <= 1'b1;
      end
   end

   // Scan timing is free-running and independent of captures.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         idx      <= 3'd0;
         seg_com  <= 8'hFF;
         seg_data <= 8'h00;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 3'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         seg_com  <= ~(8'b1 << idx);
         seg_data <= blank ? 8'h00 : decode(nib);
      end
   end
endmodule

// File: tb/tb_comparator_scan_seg.sv
// Bench for comparator_scan_seg: three instances (8-bit unsigned, 8-bit signed, 16-bit unsigned) against a value-level model.
module tb_comparator_scan_seg;
   logic        clk = 1'b0;
   logic        rst_n, load;
   logic [7:0]  a8, b8;
   logic [15:0] a16, b16;
   logic [2:0]  o_act  [3];
   logic        v_act  [3];
   logic [7:0]  sd_act [3];
   logic [7:0]  sc_act [3];

   int checks = 0;
   int fails  = 0;
   int ecount;
   int div_t [3] = '{4, 4, 3};
   int wid_t [3] = '{8, 8, 16};
   int ma8, mb8, ma16, mb16;
   logic [2:0] eo [3];
   logic       ev;

   always #5 clk = ~clk;

   comparator_scan_seg #(.WIDTH(8), .SIGNED(0), .SCAN_DIV(4)) dut_u8 (
      .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .load(load),
      .O(o_act[0]), .valid(v_act[0]), .seg_data(sd_act[0]), .seg_com(sc_act[0]));
   comparator_scan_seg #(.WIDTH(8), .SIGNED(1), .SCAN_DIV(4)) dut_s8 (
      .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .load(load),
      .O(o_act[1]), .valid(v_act[1]), .seg_data(sd_act[1]), .seg_com(sc_act[1]));
   comparator_scan_seg #(.WIDTH(16), .SIGNED(0), .SCAN_DIV(3)) dut_u16 (
      .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .load(load),
      .O(o_act[2]), .valid(v_act[2]), .seg_data(sd_act[2]), .seg_com(sc_act[2]));

   // Edges seen since the last reset release.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) ecount <= 0;
      else        ecount <= ecount + 1;

   function automatic logic [2:0] exp_cmp(input int a, input int b, input int w, input int sgn);
      if (sgn != 0) begin
         if (a >= (1 << (w - 1))) a = a - (1 << w);
         if (b >= (1 << (w - 1))) b = b - (1 << w);
      end
      if (a > b)       return 3'b100;
      else if (a == b) return 3'b010;
      else             return 3'b001;
   endfunction

   function automatic logic [7:0] seg_of(input int n);
      logic [7:0] tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
      return tbl[n];
   endfunction

   function automatic logic [7:0] exp_digit(input int val, input int w, input int p);
      int top;
      top = 0;
      if (p >= (w + 3) / 4) return 8'h00;
`ifdef LEADING_ZERO_BLANK_EN
      for (int k = 0; k < 4; k++) if (((val >> (4 * k)) & 15) != 0) top = k;
      if (p > top) return 8'h00;
`endif
      return seg_of((val >> (4 * p)) & 15);
   endfunction

   function automatic logic [7:0] exp_seg(input int d, input int ix);
      int va, vb;
      va = (d < 2) ? ma8 : ma16;
      vb = (d < 2) ? mb8 : mb16;
      return (ix >= 4) ? exp_digit(va, wid_t[d], ix - 4) : exp_digit(vb, wid_t[d], ix);
   endfunction

   task automatic drive(input logic ld, input logic [7:0] x8, input logic [7:0] y8,
                        input logic [15:0] x16, input logic [15:0] y16);
      load = ld; a8 = x8; b8 = y8; a16 = x16; b16 = y16;
      if (ld) begin
         ma8 = x8; mb8 = y8; ma16 = x16; mb16 = y16;
         eo[0] = exp_cmp(x8, y8, 8, 0);
         eo[1] = exp_cmp(x8, y8, 8, 1);
         eo[2] = exp_cmp(x16, y16, 16, 0);
         ev = 1'b1;
      end
   endtask

   task automatic model_reset();
      ma8 = 0; mb8 = 0; ma16 = 0; mb16 = 0;
      eo = '{3'b000, 3'b000, 3'b000};
      ev = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 8'h00, 8'h00, 16'h0000, 16'h0000);
      repeat (3) step();
      @(negedge clk) rst_n = 1'b1;
      repeat (6) step();
      drive(1'b1, 8'hAB, 8'hCD, 16'h1234, 16'h5678);
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (o_act[d] !== 3'b000 || v_act[d] !== 1'b0 || sc_act[d] !== 8'hFF || sd_act[d] !== 8'h00) begin
            fails++;
            $display("FAIL reset_state dut%0d: O=%b valid=%b com=%h data=%h, want 000 0 FF 00",
                     d, o_act[d], v_act[d], sc_act[d], sd_act[d]);
         end
      end
      drive(1'b0, 8'h00, 8'h00, 16'h0000, 16'h0000);
      @(negedge clk) rst_n = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (sc_act[d] !== 8'hFF) begin
            fails++;
            $display("FAIL reset_release_com dut%0d: got %h want FF", d, sc_act[d]);
         end
      end
      step();
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (sc_act[d] !== 8'hFE || sd_act[d] !== 8'h3F) begin
            fails++;
            $display("FAIL first_edge dut%0d: com=%h data=%h want FE 3F", d, sc_act[d], sd_act[d]);
         end
      end
   endtask

   task automatic test_directed_cmp();
      logic [7:0]  xa [5] = '{8'hC8, 8'h05, 8'h5A, 8'hFF, 8'h80};
      logic [7:0]  xb [5] = '{8'h05, 8'hC8, 8'h5A, 8'h01, 8'h7F};
      logic [15:0] ya [5] = '{16'hF00D, 16'h0001, 16'hFFFF, 16'h8000, 16'h1234};
      logic [15:0] yb [5] = '{16'h0000, 16'h0002, 16'hFFFF, 16'h7FFF, 16'h1234};
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, xa[i], xb[i], ya[i], yb[i]);
         step();
         drive(1'b0, xa[i], xb[i], ya[i], yb[i]);
         for (int d = 0; d < 3; d++) begin
            checks++;
            if (o_act[d] !== eo[d] || v_act[d] !== 1'b1) begin
               fails++;
               $display("FAIL directed_cmp case%0d dut%0d: O=%b valid=%b want %b 1",
                        i, d, o_act[d], v_act[d], eo[d]);
            end
         end
      end
   endtask

   task automatic test_random_cmp();
      for (int i = 0; i < 40; i++) begin
         logic [7:0]  x8, y8;
         logic [15:0] x16, y16;
         x8 = 8'($urandom); y8 = ($urandom_range(0, 3) == 0) ? x8 : 8'($urandom);
         x16 = 16'($urandom); y16 = ($urandom_range(0, 3) == 0) ? x16 : 16'($urandom);
         drive(1'($urandom_range(0, 1)), x8, y8, x16, y16);
         step();
         for (int d = 0; d < 3; d++) begin
            checks++;
            if (o_act[d] !== eo[d] || v_act[d] !== ev) begin
               fails++;
               $display("FAIL random_cmp iter%0d dut%0d: O=%b valid=%b want %b %b",
                        i, d, o_act[d], v_act[d], eo[d], ev);
            end
         end
      end
   endtask

   task automatic test_load_track();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'h40, 8'(8'h3F + i), 16'h0100, 16'(16'h00FF + i));
         step();
         for (int d = 0; d < 3; d++) begin
            checks++;
            if (o_act[d] !== eo[d]) begin
               fails++;
               $display("FAIL load_track cycle%0d dut%0d: O=%b want %b", i, d, o_act[d], eo[d]);
            end
         end
      end
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom));
         step();
         for (int d = 0; d < 3; d++) begin
            checks++;
            if (o_act[d] !== eo[d]) begin
               fails++;
               $display("FAIL load_hold cycle%0d dut%0d: O=%b want %b", i, d, o_act[d], eo[d]);
            end
         end
      end
   endtask

   // Inputs toggle throughout the scan, so the display also proves the operands stay frozen.
   task automatic test_scan(input logic [7:0] x8, input logic [7:0] y8,
                            input logic [15:0] x16, input logic [15:0] y16);
      drive(1'b1, x8, y8, x16, y16);
      step();
      for (int c = 0; c < 36; c++) begin
         drive(1'b0, 8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom));
         step();
         for (int d = 0; d < 3; d++) begin
            int ix;
            logic [7:0] ec, ed;
            ix = ((ecount - 1) / div_t[d]) % 8;
            ec = ~(8'd1 << ix);
            ed = exp_seg(d, ix);
            checks++;
            if (sc_act[d] !== ec || sd_act[d] !== ed) begin
               fails++;
               $display("FAIL scan dut%0d cycle%0d idx%0d: com=%h data=%h want %h %h",
                        d, c, ix, sc_act[d], sd_act[d], ec, ed);
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_directed_cmp();
      test_random_cmp();
      test_load_track();
      test_scan(8'h3C, 8'h07, 16'hF00D, 16'h0000);
      test_scan(8'h00, 8'hF1, 16'h00A0, 16'h0B00);
      test_scan(8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom));
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/comparator_scan_seg.md
Name: comparator_scan_seg

Overview:
Parametrised magnitude comparator with a time-multiplexed 8-digit 7-segment driver.
- Operands A and B are captured on a load strobe and compared in unsigned or signed mode; the registered one-hot result drives the LED outputs.
- Both captured operands are shown simultaneously in hex: A on the left four digits, B on the right four.
- The block sits between the board DIP switches/pushbutton and the shared 7-segment/LED pins.
- It is the clocked, generalised successor of the 3-bit combinational comparator display.

Parameters:
- WIDTH, 8, operand width in bits; legal 1..16.
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.
- SCAN_DIV, 1000, clock cycles each digit stays lit; legal ≥ 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- load  input  1  capture strobe; level-sampled each rising edge.
- O  output  3  registered result: 100 = A>B, 010 = A==B, 001 = A<B, 000 = no result yet.
- valid  output  1  high once at least one capture has occurred.
- seg_data  output  8  segment pattern, active-high; bit7 = dp, bits6..0 = g..a.
- seg_com  output  8  digit enables, active-low one-hot; bit7 = leftmost digit.

Behaviour:
- Interface rule (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values (asserted asynchronously):
  - A_r = 0, B_r = 0, O = 000, valid = 0.
  - digit index idx = 0, divider cnt = 0.
  - seg_com = 8'hFF (all digits off), seg_data = 8'h00.
- Reset mid-scan or mid-load: everything returns to the reset values immediately. No partial capture survives.
- Capture (1-cycle latency):
  - At an edge with load = 1: A_r <= A, B_r <= B, O <= compare(A, B), valid <= 1.
  - The compare uses the live inputs, so O matches A_r/B_r from the same edge.
  - load held high captures every cycle.
  - load = 0 holds A_r, B_r and O.
- Compare rule:
  - SIGNED = 0: unsigned compare.
  - SIGNED = 1: the MSB of WIDTH is the sign bit.
  - Exactly one bit of O is set after the first capture.
- Scan divider:
  - cnt counts 0..SCAN_DIV-1.
  - When cnt == SCAN_DIV-1: cnt <= 0 and idx <= idx+1 (mod 8, 7 wraps to 0).
  - Otherwise cnt <= cnt+1.
  - Runs continuously after reset, independent of load and valid.
- Digit mapping, operands zero-extended to 16 bits:
  - idx 7..4 show A_r nibbles [15:12], [11:8], [7:4], [3:0].
  - idx 3..0 show B_r nibbles [15:12], [11:8], [7:4], [3:0].
  - Signed values are shown as raw two's-complement hex.
- Unused positions: ND = ceil(WIDTH/4). Nibble positions at or above ND for each operand are blanked (seg_data = 0) but still scanned in seg_com.
- Output register (1-cycle lag behind idx):
  - Each edge: seg_com <= ~(8'b1 << idx); seg_data <= decode(nibble(idx)).
  - The first edge after reset release lights idx 0.
- Decode table (dp always 0):
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07.
  - 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71.
- A capture during a scan updates the displayed value from the next output-register edge. There is no tearing within a digit slot beyond that.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: for each operand, nibble positions above its most significant nonzero nibble are blanked (seg_data = 0). The least significant nibble is always shown, so a value of 0 displays a single "0".
- Undefined: all positions below ND display their hex nibble, including leading zeros.

Test Plan:
- Reset: hold rst_n = 0 mid-count, release → O = 000, valid = 0, seg_com = FF before the first edge; after the first edge seg_com = FE and seg_data = 3F.
- WIDTH = 8, SIGNED = 0, load pulse with A = 8'hC8, B = 8'h05 → next edge O = 100, valid = 1; then A = 8'h05, B = 8'hC8 → O = 001; then A = B = 8'h5A → O = 010.
- SIGNED = 1, WIDTH = 8, A = 8'hFF (-1), B = 8'h01 → O = 001; with SIGNED = 0 the same inputs → O = 100.
- SCAN_DIV = 4, WIDTH = 8, A_r = 8'h3C, B_r = 8'h07:
  - seg_com steps FE, FD, FB, F7, EF, DF, BF, 7F, FE, each held 4 cycles (wrap checked).
  - seg_data sequence is 07, 3F, 00, 00, 39, 4F, 00, 00 for idx 0..7.
  - With LEADING_ZERO_BLANK_EN the B[7:4] slot (idx 1) becomes 00.
- load held high 3 cycles with B changing each cycle → O tracks each cycle. load low → O, A_r and B_r frozen while the A/B inputs toggle.
- WIDTH = 16, A = 16'hF00D, B = 16'h0000 → O = 100. Digits idx 7..4 show 71, 3F, 3F, 5E. idx 3..0 show 3F, 3F, 3F, 3F without the macro, and 00, 00, 00, 3F with the macro.
